// File: rtl/qcldpc_pkg.sv
// Shared types and helpers for the QC-LDPC encode sequencer.
package qcldpc_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FEED   = 3'd1,
    DRAIN  = 3'd2,
    PARITY = 3'd3,
    OUT    = 3'd4
  } seq_state_t;

  localparam logic [2:0] ST_IDLE   = IDLE;
  localparam logic [2:0] ST_FEED   = FEED;
  localparam logic [2:0] ST_DRAIN  = DRAIN;
  localparam logic [2:0] ST_PARITY = PARITY;
  localparam logic [2:0] ST_OUT    = OUT;

  function automatic int unsigned onehot_to_idx(input logic [31:0] oh);
    int unsigned idx;
    idx = 32'd0;
    for (int i = 0; i < 32; i++) begin
      if (oh[i]) idx = $unsigned(i);
    end
    return idx;
  endfunction

  // Each Z owns a contiguous (IB+PB)*PB slice of the shift-value ROM.
  function automatic int unsigned rom_base(input int unsigned zidx,
                                           input int unsigned ib,
                                           input int unsigned pb);
    return zidx * (ib + pb) * pb;
  endfunction

endpackage

// File: rtl/qcldpc_return_tracker.sv
// Counts shifter returns, gates accumulation and (with QCLDPC_SEQ_WATCHDOG_EN)
// times out a DRAIN phase whose returns never arrive.
module qcldpc_return_tracker
  import qcldpc_pkg::*;
#(
  parameter int unsigned NUM_INFO_BLKS = 20,
  parameter int unsigned PIPE_LAT      = 7
) (
  input  logic       CLK,
  input  logic       rst_n,
  input  logic [2:0] state,
  input  logic       shf_valid_ret,
  output logic       acc_en,
  output logic       ret_done
`ifdef QCLDPC_SEQ_WATCHDOG_EN
  ,
  output logic       timeout,
  output logic       err_timeout
`endif
);

  localparam int CW = $clog2(NUM_INFO_BLKS + 1);

  if (PIPE_LAT < 1) begin : g_bad_lat
    $error("PIPE_LAT must be at least 1");
  end

  logic [CW-1:0] ret_cnt_r;

  assign acc_en   = shf_valid_ret & ((state == ST_FEED) | (state == ST_DRAIN));
  // Done also fires in the very cycle the last return lands.
  assign ret_done = (ret_cnt_r == CW'(NUM_INFO_BLKS)) |
                    (acc_en & (ret_cnt_r == CW'(NUM_INFO_BLKS - 1)));

  // Return counter, cleared whenever the sequencer is idle.
  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      ret_cnt_r <= '0;
    end else if (state == ST_IDLE) begin
      ret_cnt_r <= '0;
    end else if (acc_en && (ret_cnt_r != CW'(NUM_INFO_BLKS))) begin
      ret_cnt_r <= ret_cnt_r + CW'(1);
    end
  end

`ifdef QCLDPC_SEQ_WATCHDOG_EN
  localparam int unsigned LIMIT = PIPE_LAT + NUM_INFO_BLKS + 2;
  localparam int DW = $clog2(LIMIT + 1);

  logic [DW-1:0] drain_cnt_r;

  assign timeout = (state == ST_DRAIN) & (drain_cnt_r == DW'(LIMIT - 1)) & ~ret_done;

  // DRAIN residency counter and registered timeout pulse.
  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      drain_cnt_r <= '0;
      err_timeout <= 1'b0;
    end else begin
      err_timeout <= timeout;
      if (state != ST_DRAIN) begin
        drain_cnt_r <= '0;
      end else if (drain_cnt_r != DW'(LIMIT)) begin
        drain_cnt_r <= drain_cnt_r + DW'(1);
      end
    end
  end
`endif

endmodule

// File: rtl/qcldpc_encode_sequencer.sv
// Control FSM sequencing one QC-LDPC block through ROM, shifters and accumulators.
// Optional DRAIN watchdog: define QCLDPC_SEQ_WATCHDOG_EN.
module qcldpc_encode_sequencer
  import qcldpc_pkg::*;
#(
  parameter int unsigned NUM_Z           = 3,
  parameter int unsigned NUM_INFO_BLKS   = 20,
  parameter int unsigned NUM_PARITY_BLKS = 4,
  parameter int unsigned PIPE_LAT        = 7,
  parameter int unsigned PARITY_CYCLES   = 4,
  parameter int unsigned ROM_AW          = 9
) (
  input  logic              CLK,
  input  logic              rst_n,
  input  logic [NUM_Z-1:0]  req_z,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic [ROM_AW-1:0] rom_addr,
  output logic              shf_valid,
  input  logic              shf_valid_ret,
  output logic              acc_clr,
  output logic              acc_en,
  output logic              par_gen,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              err_z,
  output logic              err_last
`ifdef QCLDPC_SEQ_WATCHDOG_EN
  ,
  output logic              err_timeout
`endif
);

  localparam int CW = $clog2(NUM_INFO_BLKS + 1);
  localparam int ZW = (NUM_Z > 1) ? $clog2(NUM_Z) : 1;
  localparam int PW = $clog2(PARITY_CYCLES + 1);

  if (ROM_AW < $clog2((NUM_INFO_BLKS + NUM_PARITY_BLKS) * NUM_PARITY_BLKS * NUM_Z)) begin : g_bad_aw
    $error("ROM_AW too small for the ROM layout");
  end

  logic [2:0]        state_r;
  logic [CW-1:0]     col_cnt_r;
  logic [ZW-1:0]     zidx_r;
  logic [PW-1:0]     par_cnt_r;
  logic              accept_s;
  logic              ret_done_s;
  logic              timeout_s;
  logic [ZW-1:0]     zidx_new_s;
  logic [ROM_AW-1:0] base_new_s;
  logic [ROM_AW-1:0] base_cur_s;

  assign in_ready   = (state_r == ST_IDLE) | (state_r == ST_FEED);
  assign busy       = (state_r != ST_IDLE);
  assign accept_s   = in_valid & in_ready;
  assign zidx_new_s = ZW'(onehot_to_idx(32'(req_z)));
  assign base_new_s = ROM_AW'(rom_base(32'(zidx_new_s), NUM_INFO_BLKS, NUM_PARITY_BLKS));
  assign base_cur_s = ROM_AW'(rom_base(32'(zidx_r), NUM_INFO_BLKS, NUM_PARITY_BLKS));

  qcldpc_return_tracker #(
    .NUM_INFO_BLKS (NUM_INFO_BLKS),
    .PIPE_LAT      (PIPE_LAT)
  ) u_tracker (
    .CLK           (CLK),
    .rst_n         (rst_n),
    .state         (state_r),
    .shf_valid_ret (shf_valid_ret),
    .acc_en        (acc_en),
    .ret_done      (ret_done_s)
`ifdef QCLDPC_SEQ_WATCHDOG_EN
    ,
    .timeout       (timeout_s),
    .err_timeout   (err_timeout)
`endif
  );

`ifndef QCLDPC_SEQ_WATCHDOG_EN
  assign timeout_s = 1'b0;
`endif

  // Sequencer FSM with registered datapath controls and error pulses.
  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      col_cnt_r <= '0;
      zidx_r    <= '0;
      par_cnt_r <= '0;
      rom_addr  <= '0;
      shf_valid <= 1'b0;
      acc_clr   <= 1'b0;
      par_gen   <= 1'b0;
      out_valid <= 1'b0;
      err_z     <= 1'b0;
      err_last  <= 1'b0;
    end else begin
      shf_valid <= 1'b0;
      acc_clr   <= 1'b0;
      err_z     <= 1'b0;
      err_last  <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            if (!$onehot(req_z)) begin
              err_z <= 1'b1;
            end else if (in_last) begin
              // A one-beat block is always early; nothing is launched.
              zidx_r   <= zidx_new_s;
              err_last <= 1'b1;
              acc_clr  <= 1'b1;
            end else begin
              zidx_r    <= zidx_new_s;
              rom_addr  <= base_new_s;
              shf_valid <= 1'b1;
              acc_clr   <= 1'b1;
              col_cnt_r <= CW'(1);
              state_r   <= ST_FEED;
            end
          end
        end
        ST_FEED: begin
          if (accept_s) begin
            if (col_cnt_r == CW'(NUM_INFO_BLKS - 1)) begin
              rom_addr  <= base_cur_s + ROM_AW'(col_cnt_r);
              shf_valid <= 1'b1;
              col_cnt_r <= col_cnt_r + CW'(1);
              err_last  <= ~in_last;
              state_r   <= ST_DRAIN;
            end else if (in_last) begin
              err_last  <= 1'b1;
              acc_clr   <= 1'b1;
              col_cnt_r <= '0;
              state_r   <= ST_IDLE;
            end else begin
              rom_addr  <= base_cur_s + ROM_AW'(col_cnt_r);
              shf_valid <= 1'b1;
              col_cnt_r <= col_cnt_r + CW'(1);
            end
          end
        end
        ST_DRAIN: begin
          if (timeout_s) begin
            acc_clr   <= 1'b1;
            col_cnt_r <= '0;
            state_r   <= ST_IDLE;
          end else if (ret_done_s) begin
            par_cnt_r <= '0;
            par_gen   <= 1'b1;
            state_r   <= ST_PARITY;
          end
        end
        ST_PARITY: begin
          if (par_cnt_r == PW'(PARITY_CYCLES - 1)) begin
            par_gen   <= 1'b0;
            out_valid <= 1'b1;
            state_r   <= ST_OUT;
          end else begin
            par_cnt_r <= par_cnt_r + PW'(1);
          end
        end
        ST_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            col_cnt_r <= '0;
            state_r   <= ST_IDLE;
          end
        end
        default: begin
          par_gen   <= 1'b0;
          out_valid <= 1'b0;
          col_cnt_r <= '0;
          state_r   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_qcldpc_encode_sequencer.sv
// Directed self-checking bench for qcldpc_encode_sequencer with a delay-line shifter model.
module tb_qcldpc_encode_sequencer;

  localparam int PL = 7;

  logic       CLK = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] req_z = 3'b000;
  logic       in_valid = 1'b0;
  logic       in_last = 1'b0;
  logic       in_ready;
  logic [8:0] rom_addr;
  logic       shf_valid;
  logic       shf_valid_ret;
  logic       acc_clr, acc_en, par_gen, out_valid, busy, err_z, err_last;
  logic       out_ready = 1'b0;
`ifdef QCLDPC_SEQ_WATCHDOG_EN
  logic       err_timeout;
`endif

  logic [PL-1:0] pipe = '0;
  logic          ret_en = 1'b1;
  logic          inject = 1'b0;

  int tests = 0;
  int fails = 0;

  int       cyc = 0;
  int       acc_n = 0, par_n = 0, clr_n = 0, elast_n = 0, shf_n = 0;
  logic [8:0] addr_log [0:511];
  int       cyc_log [0:511];

  qcldpc_encode_sequencer dut (
    .CLK(CLK), .rst_n(rst_n), .req_z(req_z), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .rom_addr(rom_addr), .shf_valid(shf_valid),
    .shf_valid_ret(shf_valid_ret), .acc_clr(acc_clr), .acc_en(acc_en), .par_gen(par_gen),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .err_z(err_z),
    .err_last(err_last)
`ifdef QCLDPC_SEQ_WATCHDOG_EN
    , .err_timeout(err_timeout)
`endif
  );

  always #5 CLK = ~CLK;

  // Shifter bank stand-in: shf_valid reappears PL cycles later.
  always @(posedge CLK) pipe <= {pipe[PL-2:0], shf_valid};
  assign shf_valid_ret = (pipe[PL-1] & ret_en) | inject;

  // Event monitor sampled mid-cycle.
  always @(negedge CLK) begin
    cyc <= cyc + 1;
    if (acc_en)   acc_n   <= acc_n + 1;
    if (par_gen)  par_n   <= par_n + 1;
    if (acc_clr)  clr_n   <= clr_n + 1;
    if (err_last) elast_n <= elast_n + 1;
    if (shf_valid && shf_n < 512) begin
      addr_log[shf_n] <= rom_addr;
      cyc_log[shf_n]  <= cyc;
      shf_n           <= shf_n + 1;
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send_block(input logic [2:0] z, input int n, input int last_at, input int gap);
    for (int b = 1; b <= n; b++) begin
      int   w;
      logic ok;
      req_z = z; in_valid = 1'b1; in_last = (b == last_at); w = 0; ok = 1'b0;
      while (!ok && w < 50) begin
        ok = in_ready;
        tick();
        w++;
      end
      in_valid = 1'b0; in_last = 1'b0;
      if (!ok) begin
        tests++; fails++;
        $display("FAIL send_beat: beat %0d in_ready=0 required 1", b);
      end
      for (int g = 0; g < gap; g++) tick();
    end
  endtask

  task automatic wait_out(input string name);
    int n;
    n = 0;
    while (!out_valid && n < 200) begin
      tick();
      n++;
    end
    tests++;
    if (out_valid !== 1'b1) begin
      fails++;
      $display("FAIL %s_out_valid: got %b required 1", name, out_valid);
    end
  endtask

  task automatic finish_out();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    tests++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL out_handshake: out_valid=%b busy=%b required 0 0", out_valid, busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    tests++;
    if ({rom_addr, shf_valid, acc_clr, acc_en, par_gen, out_valid, busy, err_z, err_last} !== 17'd0
        || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_outputs: addr=%0d shf=%b clr=%b en=%b par=%b ov=%b busy=%b ez=%b el=%b rdy=%b required 0..0 rdy=1",
               rom_addr, shf_valid, acc_clr, acc_en, par_gen, out_valid, busy, err_z, err_last, in_ready);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_full_block();
    int s0, a0, p0, c0;
    s0 = shf_n; a0 = acc_n; p0 = par_n; c0 = clr_n;
    send_block(3'b100, 20, 20, 0);
    wait_out("full");
    tests++;
    if (shf_n - s0 !== 20) begin fails++; $display("FAIL full_shf_count: got %0d required 20", shf_n - s0); end
    for (int i = 0; i < 20 && s0 + i < shf_n; i++) begin
      tests++;
      if (addr_log[s0+i] !== 9'(192 + i)) begin
        fails++; $display("FAIL full_rom_addr[%0d]: got %0d required %0d", i, addr_log[s0+i], 192 + i);
      end
    end
    tests++;
    if (cyc_log[s0+19] - cyc_log[s0] !== 19) begin
      fails++; $display("FAIL full_consecutive: span %0d required 19", cyc_log[s0+19] - cyc_log[s0]);
    end
    tests++;
    if (acc_n - a0 !== 20) begin fails++; $display("FAIL full_acc_en: got %0d required 20", acc_n - a0); end
    tests++;
    if (par_n - p0 !== 4) begin fails++; $display("FAIL full_par_gen: got %0d required 4", par_n - p0); end
    tests++;
    if (clr_n - c0 !== 1) begin fails++; $display("FAIL full_acc_clr: got %0d required 1", clr_n - c0); end
    finish_out();
  endtask

  task automatic test_bubbles();
    int s0, a0;
    s0 = shf_n; a0 = acc_n;
    send_block(3'b010, 20, 20, 1);
    wait_out("bubble");
    for (int i = 0; i < 20; i += 19) begin
      tests++;
      if (addr_log[s0+i] !== 9'(96 + i)) begin
        fails++; $display("FAIL bubble_rom_addr[%0d]: got %0d required %0d", i, addr_log[s0+i], 96 + i);
      end
    end
    tests++;
    if (cyc_log[s0+1] - cyc_log[s0] !== 2) begin
      fails++; $display("FAIL bubble_gap: got %0d required 2", cyc_log[s0+1] - cyc_log[s0]);
    end
    tests++;
    if (acc_n - a0 !== 20) begin fails++; $display("FAIL bubble_acc_en: got %0d required 20", acc_n - a0); end
    finish_out();
  endtask

  task automatic test_bad_z();
    int s0;
    s0 = shf_n;
    send_block(3'b011, 1, 0, 0);
    tests++;
    if (err_z !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b1 || shf_valid !== 1'b0) begin
      fails++; $display("FAIL bad_z_pulse: err_z=%b busy=%b rdy=%b shf=%b required 1 0 1 0",
                        err_z, busy, in_ready, shf_valid);
    end
    tick();
    tests++;
    if (err_z !== 1'b0) begin fails++; $display("FAIL bad_z_width: err_z=%b required 0", err_z); end
    send_block(3'b001, 20, 20, 0);
    wait_out("after_bad_z");
    tests++;
    if (addr_log[s0] !== 9'd0 || addr_log[s0+19] !== 9'd19) begin
      fails++; $display("FAIL after_bad_z_addr: first %0d last %0d required 0 19", addr_log[s0], addr_log[s0+19]);
    end
    finish_out();
  endtask

  task automatic test_last_errors();
    int s0, e0;
    s0 = shf_n;
    send_block(3'b001, 5, 5, 0);
    tests++;
    if (err_last !== 1'b1 || acc_clr !== 1'b1 || busy !== 1'b0 || shf_valid !== 1'b0) begin
      fails++; $display("FAIL early_last: err_last=%b acc_clr=%b busy=%b shf=%b required 1 1 0 0",
                        err_last, acc_clr, busy, shf_valid);
    end
    tests++;
    if (shf_n - s0 !== 4) begin fails++; $display("FAIL early_last_launches: got %0d required 4", shf_n - s0); end
    for (int i = 0; i < 12; i++) tick();
    e0 = elast_n;
    send_block(3'b001, 20, 0, 0);
    tests++;
    if (err_last !== 1'b1 || busy !== 1'b1) begin
      fails++; $display("FAIL missing_last: err_last=%b busy=%b required 1 1", err_last, busy);
    end
    wait_out("missing_last");
    tests++;
    if (elast_n - e0 !== 1) begin fails++; $display("FAIL missing_last_count: got %0d required 1", elast_n - e0); end
    finish_out();
  endtask

  task automatic test_back_to_back();
    int bad;
    send_block(3'b001, 20, 20, 0);
    wait_out("stall");
    req_z = 3'b001; in_valid = 1'b1; in_last = 1'b0; bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (out_valid !== 1'b1 || in_ready !== 1'b0) bad++;
    end
    tests++;
    if (bad != 0) begin fails++; $display("FAIL stall_hold: %0d bad cycles required 0", bad); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || shf_valid !== 1'b0) begin
      fails++; $display("FAIL handshake_edge: ov=%b rdy=%b shf=%b required 0 1 0", out_valid, in_ready, shf_valid);
    end
    tick();
    in_valid = 1'b0;
    tests++;
    if (shf_valid !== 1'b1 || rom_addr !== 9'd0 || busy !== 1'b1) begin
      fails++; $display("FAIL resume_accept: shf=%b addr=%0d busy=%b required 1 0 1", shf_valid, rom_addr, busy);
    end
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    for (int i = 0; i < 12; i++) tick();
  endtask

  task automatic test_reset_in_drain();
    int a0, bad;
    ret_en = 1'b0;
    send_block(3'b100, 20, 20, 0);
    tick(); tick();
    tests++;
    if (busy !== 1'b1 || out_valid !== 1'b0) begin
      fails++; $display("FAIL drain_wait: busy=%b ov=%b required 1 0", busy, out_valid);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tests++;
    if ({rom_addr, shf_valid, acc_clr, par_gen, out_valid, busy, err_z, err_last} !== 16'd0) begin
      fails++; $display("FAIL drain_reset: addr=%0d shf=%b clr=%b par=%b ov=%b busy=%b required all 0",
                        rom_addr, shf_valid, acc_clr, par_gen, out_valid, busy);
    end
    a0 = acc_n; bad = 0; inject = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (acc_en !== 1'b0) bad++;
      tick();
    end
    inject = 1'b0;
    tick();
    tests++;
    if (bad != 0 || acc_n != a0) begin
      fails++; $display("FAIL late_returns: acc_en seen %0d/%0d required 0", bad, acc_n - a0);
    end
    ret_en = 1'b1;
    for (int i = 0; i < 12; i++) tick();
  endtask

`ifdef QCLDPC_SEQ_WATCHDOG_EN
  task automatic test_watchdog();
    int n;
    ret_en = 1'b0;
    send_block(3'b010, 20, 20, 0);
    n = 0;
    while (err_timeout !== 1'b1 && n < 60) begin
      tick();
      n++;
    end
    tests++;
    if (n != 29 || acc_clr !== 1'b1 || busy !== 1'b0) begin
      fails++; $display("FAIL watchdog: after %0d cycles clr=%b busy=%b required 29 1 0", n, acc_clr, busy);
    end
    ret_en = 1'b1;
    for (int i = 0; i < 12; i++) tick();
  endtask
`endif

  initial begin
    test_reset();
    test_full_block();
    test_bubbles();
    test_bad_z();
    test_last_errors();
    test_back_to_back();
    test_reset_in_drain();
`ifdef QCLDPC_SEQ_WATCHDOG_EN
    test_watchdog();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
